// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs buffered mult/div results.
// Optional perf counters: define WB_ARB_PERF_EN.
module wb_port_arbiter #(
  parameter int MD_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        flush,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_wsel,
  input  logic [31:0] pipe_wdat,
  input  logic        md_valid,
  input  logic [4:0]  md_wsel,
  input  logic [31:0] md_wdat,
  output logic        md_ready,
  output logic        rf_wen,
  output logic [4:0]  rf_wsel,
  output logic [31:0] rf_wdat,
  output logic        wb_stall
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_drain_cnt
`endif
);

  localparam int AW = $clog2(MD_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [0:0] {
    PIPE_PRI = 1'b0,
    DRAIN    = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW-1:0]       r_wr_ptr;
  logic [CW-1:0]       r_count;
  logic [SW-1:0]       r_starve;
  logic [SW-1:0]       w_starve_nx;
  logic [MD_DEPTH-1:0] r_vld;
  logic [4:0]          r_sel [MD_DEPTH];
  logic [31:0]         r_dat [MD_DEPTH];

  logic w_preq;
  logic w_conflict;
  logic w_empty;
  logic w_ready;
  logic w_push;
  logic w_last;
  logic w_pop;
  logic w_grant;
  logic w_stall;
  logic w_starved;

  // Request qualification, WAW hazard detection and buffer status
  always_comb begin
    w_preq     = pipe_wen & ~flush & (pipe_wsel != 5'd0);
    w_conflict = 1'b0;
    for (int i = 0; i < MD_DEPTH; i++) begin
      w_conflict = w_conflict | (r_vld[i] & (r_sel[i] == pipe_wsel));
    end
    w_conflict = w_conflict & w_preq;
    w_empty    = (r_count == CW'(0));
    w_ready    = (r_count < CW'(MD_DEPTH));
    w_push     = md_valid & w_ready & (md_wsel != 5'd0);
    w_last     = (r_count == CW'(1)) & ~w_push;
    w_starved  = w_preq & (r_starve == SW'(STARVE_MAX)) & ~w_empty;
  end

  // Arbitration and next-state decision
  always_comb begin
    w_pop       = 1'b0;
    w_grant     = 1'b0;
    w_stall     = 1'b0;
    w_state_nx  = r_state;
    w_starve_nx = r_starve;
    case (r_state)
      PIPE_PRI: begin
        if (w_conflict || w_starved) begin
          w_pop       = 1'b1;
          w_stall     = 1'b1;
          w_starve_nx = SW'(0);
          // A single-entry drain finishes in the same cycle it starts.
          w_state_nx  = w_last ? PIPE_PRI : DRAIN;
        end else if (w_preq) begin
          w_grant = 1'b1;
          if (w_empty) begin
            w_starve_nx = SW'(0);
          end else if (r_starve == SW'(STARVE_MAX)) begin
            w_starve_nx = r_starve;
          end else begin
            w_starve_nx = r_starve + SW'(1);
          end
        end else if (!w_empty) begin
          w_pop       = 1'b1;
          w_starve_nx = SW'(0);
        end else begin
          w_pop = 1'b0;
        end
      end
      DRAIN: begin
        w_stall = w_preq;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nx  = w_last ? PIPE_PRI : DRAIN;
          w_starve_nx = w_last ? SW'(0) : r_starve;
        end else begin
          w_state_nx  = PIPE_PRI;
          w_starve_nx = SW'(0);
        end
      end
      default: begin
        w_state_nx  = PIPE_PRI;
        w_starve_nx = SW'(0);
      end
    endcase
  end

  // Write-port mux; everything reads as zero while reset is held
  always_comb begin
    rf_wen  = 1'b0;
    rf_wsel = 5'd0;
    rf_wdat = 32'd0;
    if (RST) begin
      rf_wen = 1'b0;
    end else if (w_pop) begin
      rf_wen  = 1'b1;
      rf_wsel = r_sel[r_rd_ptr];
      rf_wdat = r_dat[r_rd_ptr];
    end else if (w_grant) begin
      rf_wen  = 1'b1;
      rf_wsel = pipe_wsel;
      rf_wdat = pipe_wdat;
    end else begin
      rf_wen = 1'b0;
    end
  end

  assign wb_stall = ~RST & w_stall;
  assign md_ready = ~RST & w_ready;

  // Control state, pointers, occupancy and per-entry valid bits
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= PIPE_PRI;
      r_rd_ptr <= AW'(0);
      r_wr_ptr <= AW'(0);
      r_count  <= CW'(0);
      r_starve <= SW'(0);
      r_vld    <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_starve <= w_starve_nx;
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + AW'(1);
      end
      if (w_push) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
    end
  end

  // Buffer payload storage; validity is tracked by r_vld and r_count
  always_ff @(posedge CLK) begin
    if (!RST && w_push) begin
      r_sel[r_wr_ptr] <= md_wsel;
      r_dat[r_wr_ptr] <= md_wdat;
    end
  end

`ifdef WB_ARB_PERF_EN
  // Stall-cycle and drain-entry counters, free-running modulo 2^32
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_stall_cnt <= 32'd0;
      perf_drain_cnt <= 32'd0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + {31'd0, w_stall};
      perf_drain_cnt <= perf_drain_cnt +
                        {31'd0, (r_state == PIPE_PRI) && (w_state_nx == DRAIN)};
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        flush, pipe_wen, md_valid;
  logic [4:0]  pipe_wsel, md_wsel;
  logic [31:0] pipe_wdat, md_wdat;
  logic        md_ready, rf_wen, wb_stall;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;

  int checks = 0;
  int fails  = 0;

  wb_port_arbiter #(.MD_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .pipe_wen(pipe_wen), .pipe_wsel(pipe_wsel), .pipe_wdat(pipe_wdat),
    .md_valid(md_valid), .md_wsel(md_wsel), .md_wdat(md_wdat),
    .md_ready(md_ready), .rf_wen(rf_wen), .rf_wsel(rf_wsel),
    .rf_wdat(rf_wdat), .wb_stall(wb_stall)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending mult/div results as a queue of {sel,dat}
  typedef struct packed { logic [4:0] sel; logic [31:0] dat; } ent_t;
  ent_t        mq[$];
  int          m_starve = 0;
  bit          m_drain  = 0;
  bit          m_preq, m_hit, m_pop, m_grant, m_stall, m_force, m_ready;
  logic [4:0]  e_sel;
  logic [31:0] e_dat;

  always @(negedge CLK) begin
    if (RST) begin
      chk("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
      chk("rst_wb_stall", {31'd0, wb_stall}, 32'd0);
      chk("rst_md_ready", {31'd0, md_ready}, 32'd0);
      chk("rst_rf_wsel", {27'd0, rf_wsel}, 32'd0);
      chk("rst_rf_wdat", rf_wdat, 32'd0);
      mq.delete();
      m_starve = 0;
      m_drain  = 0;
    end else begin
      m_preq  = pipe_wen && !flush && (pipe_wsel != 5'd0);
      m_hit   = 1'b0;
      foreach (mq[i]) if (m_preq && mq[i].sel == pipe_wsel) m_hit = 1'b1;
      m_ready = (mq.size() < DEPTH);
      m_pop = 0; m_grant = 0; m_stall = 0; m_force = 0;
      if (m_drain && mq.size() > 0) begin
        m_pop = 1; m_stall = m_preq; m_force = 1;
      end else if (m_hit || (m_preq && m_starve == SMAX && mq.size() > 0)) begin
        m_pop = 1; m_stall = 1; m_force = 1;
      end else if (m_preq) begin
        m_grant  = 1;
        m_starve = (mq.size() > 0) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
      end else if (mq.size() > 0) begin
        m_pop = 1;
      end
      e_sel = 5'd0; e_dat = 32'd0;
      if (m_pop) begin e_sel = mq[0].sel; e_dat = mq[0].dat; end
      else if (m_grant) begin e_sel = pipe_wsel; e_dat = pipe_wdat; end
      chk("rf_wen", {31'd0, rf_wen}, {31'd0, (m_pop || m_grant)});
      chk("rf_wsel", {27'd0, rf_wsel}, {27'd0, e_sel});
      chk("rf_wdat", rf_wdat, e_dat);
      chk("wb_stall", {31'd0, wb_stall}, {31'd0, m_stall});
      chk("md_ready", {31'd0, md_ready}, {31'd0, m_ready});
      if (m_pop) begin void'(mq.pop_front()); m_starve = 0; end
      if (md_valid && m_ready && md_wsel != 5'd0) mq.push_back('{md_wsel, md_wdat});
      m_drain = m_force && (mq.size() > 0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv(input logic pw, input logic [4:0] ps, input logic [31:0] pd,
                     input logic fl, input logic mv, input logic [4:0] ms,
                     input logic [31:0] md);
    tick();
    pipe_wen = pw; pipe_wsel = ps; pipe_wdat = pd; flush = fl;
    md_valid = mv; md_wsel = ms; md_wdat = md;
    #2;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic lit(input string nm, input logic w, input logic [4:0] s,
                     input logic [31:0] d, input logic st);
    chk({nm, "_wen"}, {31'd0, rf_wen}, {31'd0, w});
    chk({nm, "_wsel"}, {27'd0, rf_wsel}, {27'd0, s});
    chk({nm, "_wdat"}, rf_wdat, d);
    chk({nm, "_stall"}, {31'd0, wb_stall}, {31'd0, st});
  endtask

  initial begin
    RST = 1'b1; flush = 0; pipe_wen = 0; pipe_wsel = 0; pipe_wdat = 0;
    md_valid = 0; md_wsel = 0; md_wdat = 0;
    tick(); tick(); #2;
    chk("in_reset_md_ready", {31'd0, md_ready}, 32'd0);
    tick(); RST = 1'b0; #2;
    chk("idle_md_ready", {31'd0, md_ready}, 32'd1);
    lit("idle", 0, 5'd0, 32'd0, 0);

    // Lone mult/div result drains on the following cycle
    drv(0, 5'd0, 32'd0, 0, 1, 5'd3, 32'hAAAA0001);
    lit("md_accept", 0, 5'd0, 32'd0, 0);
    idle();
    lit("md_drain", 1, 5'd3, 32'hAAAA0001, 0);
    idle();
    lit("md_empty", 0, 5'd0, 32'd0, 0);

    // WAW conflict on r5
    drv(1, 5'd12, 32'h12, 0, 1, 5'd5, 32'h55);
    lit("waw_load", 1, 5'd12, 32'h12, 0);
    drv(1, 5'd5, 32'h22, 0, 0, 5'd0, 32'd0);
    lit("waw_c1", 1, 5'd5, 32'h55, 1);
    drv(1, 5'd5, 32'h22, 0, 0, 5'd0, 32'd0);
    lit("waw_c2", 1, 5'd5, 32'h22, 0);
    idle();

    // Starvation: r8/r9 buffered behind a continuous pipe stream
    drv(1, 5'd10, 32'h10, 0, 1, 5'd8, 32'h88);
    lit("stv_l1", 1, 5'd10, 32'h10, 0);
    drv(1, 5'd11, 32'h11, 0, 1, 5'd9, 32'h99);
    lit("stv_l2", 1, 5'd11, 32'h11, 0);
    for (int i = 1; i <= 3; i++) begin
      drv(1, 5'(i), 32'(i), 0, 0, 5'd0, 32'd0);
      lit("stv_pipe", 1, 5'(i), 32'(i), 0);
    end
    drv(1, 5'd4, 32'h4, 0, 0, 5'd0, 32'd0);
    lit("stv_r8", 1, 5'd8, 32'h88, 1);
    drv(1, 5'd4, 32'h4, 0, 0, 5'd0, 32'd0);
    lit("stv_r9", 1, 5'd9, 32'h99, 1);
    drv(1, 5'd4, 32'h4, 0, 0, 5'd0, 32'd0);
    lit("stv_r4", 1, 5'd4, 32'h4, 0);
    idle();

    // Fill buffer while the pipe writes every cycle
    drv(1, 5'd13, 32'h13, 0, 1, 5'd20, 32'h20);
    drv(1, 5'd14, 32'h14, 0, 1, 5'd21, 32'h21);
    drv(1, 5'd15, 32'h15, 0, 1, 5'd22, 32'h22);
    chk("full_md_ready", {31'd0, md_ready}, 32'd0);
    drv(1, 5'd16, 32'h16, 0, 1, 5'd22, 32'h22);
    drv(1, 5'd17, 32'h17, 0, 1, 5'd22, 32'h22);
    drv(1, 5'd18, 32'h18, 0, 1, 5'd22, 32'h22);
    lit("full_force", 1, 5'd20, 32'h20, 1);
    chk("full_still_full", {31'd0, md_ready}, 32'd0);
    drv(1, 5'd18, 32'h18, 0, 1, 5'd22, 32'h22);
    chk("full_ready_rise", {31'd0, md_ready}, 32'd1);
    lit("full_r21", 1, 5'd21, 32'h21, 1);
    drv(1, 5'd18, 32'h18, 0, 0, 5'd0, 32'd0);
    lit("full_r22", 1, 5'd22, 32'h22, 1);
    drv(1, 5'd18, 32'h18, 0, 0, 5'd0, 32'd0);
    lit("full_pipe", 1, 5'd18, 32'h18, 0);
    idle();

    // Flush squashes only the pipe request
    drv(1, 5'd12, 32'h12, 0, 1, 5'd7, 32'h77);
    drv(1, 5'd7, 32'hDEAD, 1, 0, 5'd0, 32'd0);
    lit("flush", 1, 5'd7, 32'h77, 0);
    idle();
    lit("flush_after", 0, 5'd0, 32'd0, 0);

    // Reset in the middle of a drain
    drv(1, 5'd10, 32'h10, 0, 1, 5'd8, 32'h81);
    drv(1, 5'd11, 32'h11, 0, 1, 5'd9, 32'h91);
    drv(1, 5'd8, 32'h8, 0, 0, 5'd0, 32'd0);
    lit("rd_pop", 1, 5'd8, 32'h81, 1);
    tick(); RST = 1'b1; pipe_wen = 0; pipe_wsel = 0; pipe_wdat = 0; #2;
    lit("rd_rst", 0, 5'd0, 32'd0, 0);
    tick(); RST = 1'b0; #2;
    lit("rd_after", 0, 5'd0, 32'd0, 0);
    chk("rd_after_ready", {31'd0, md_ready}, 32'd1);
    idle();
    lit("rd_after2", 0, 5'd0, 32'd0, 0);

    // Randomized traffic over a small register range to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      tick();
      RST       = ($urandom_range(0, 199) == 0);
      pipe_wen  = ($urandom_range(0, 9) < 7);
      pipe_wsel = 5'($urandom_range(0, 7));
      pipe_wdat = $urandom;
      flush     = ($urandom_range(0, 9) == 0);
      md_valid  = ($urandom_range(0, 9) < 4);
      md_wsel   = 5'($urandom_range(0, 7));
      md_wdat   = $urandom;
    end
    tick();
    RST = 1'b0;
    idle(); idle(); idle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Schedules the single register-file write port between two sources: the in-order pipeline writeback stage and the multicycle mult/div unit's completion path.
- Mult/div results are held in a small in-order buffer and drained into idle port cycles.
- Starvation and write-after-write hazards force a drain and stall the writeback stage.
- Sits between the writeback stage output, the mult/div unit and the register file; drives the writeback stall.

Parameters:
MD_DEPTH, 2, mult/div result buffer entries (power of 2, >=2)
STARVE_MAX, 4, consecutive pipe-granted cycles with non-empty buffer before a forced drain

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
flush  in  1  squash current pipe write request
pipe_wen  in  1  writeback-stage register write request
pipe_wsel  in  5  writeback-stage destination register
pipe_wdat  in  32  writeback-stage write data
md_valid  in  1  mult/div result valid
md_wsel  in  5  mult/div destination register
md_wdat  in  32  mult/div result data
md_ready  out  1  buffer can accept; count < MD_DEPTH (registered state only)
rf_wen  out  1  register-file write enable
rf_wsel  out  5  register-file write select
rf_wdat  out  32  register-file write data
wb_stall  out  1  pipe request not granted this cycle; writeback must hold

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high.
- While RST is high, all outputs are 0, md_ready included. At the next edge: buffer empty, count=0, starve counter=0, state=PIPE_PRI. After reset, md_ready=1.
- Grant path is combinational, zero latency: rf_* reflects this cycle's winner. Buffer and counter updates occur at the clock edge.
- Effective pipe request: preq = pipe_wen & ~flush & (pipe_wsel != 0).
- pipe_wen with pipe_wsel=0 and no flush: no write, wb_stall=0.
- Enqueue happens when md_valid & md_ready. md_wsel=0 results are accepted and discarded without enqueue. md_valid while md_ready=0 is ignored; the producer holds.
- Enqueue is evaluated on registered count only: a full buffer rejects even if it pops in the same cycle.
- Buffer is FIFO-ordered with wrap-around pointers. Enqueue and pop in the same cycle leave count unchanged.
- WAW conflict: preq and pipe_wsel equals the wsel of any valid buffered entry.
- State PIPE_PRI:
  - Conflict: pop buffer head to the port, wb_stall=1, move to DRAIN.
  - Else if preq and starve==STARVE_MAX with buffer non-empty: pop head, wb_stall=1, move to DRAIN.
  - Else if preq: grant pipe, wb_stall=0. starve increments if the buffer is non-empty (saturating), otherwise clears.
  - Else if buffer non-empty: pop head, starve clears.
  - Else: rf_wen=0.
- State DRAIN:
  - Pop head every cycle. wb_stall=preq.
  - When the popped entry is the last one (count==1, no enqueue that cycle), return to PIPE_PRI and clear starve.
  - Enqueues during DRAIN extend the drain.
- Flush in any state only squashes the pipe request. Buffered mult/div results are architecturally committed and are never discarded by flush.
- A write is never lost or duplicated. Writes to one register appear in program order (buffer FIFO plus the conflict rule).
- rf_wen=0 implies rf_wsel=0 and rf_wdat=0.

Optional Feature:
WB_ARB_PERF_EN
- When defined, adds outputs perf_stall_cnt (32) and perf_drain_cnt (32).
  - perf_stall_cnt counts cycles with wb_stall=1.
  - perf_drain_cnt counts PIPE_PRI->DRAIN transitions.
  - Both wrap modulo 2^32 and clear on RST.
- When undefined, these ports and counters do not exist. Arbitration behaviour is identical either way.

Test Plan:
- Reset, then idle: md_ready=1, rf_wen=0, wb_stall=0. Drive RST for 1 cycle mid-drain with 2 entries buffered -> next cycle count=0, state PIPE_PRI, no further writes.
- md_valid with wsel=3, wdat=0xAAAA0001 while pipe_wen=0 -> next cycle rf_wen=1, rf_wsel=3, rf_wdat=0xAAAA0001, count returns 0.
- Buffer holds entry for r5; pipe writes r5=0x22 -> cycle 1: rf writes buffered r5, wb_stall=1; cycle 2: rf writes r5=0x22, wb_stall=0.
- Buffer holds entries for r8 and r9; pipe writes r1..r6 each cycle:
  - pipe granted 4 cycles (STARVE_MAX=4).
  - Cycles 5-6: r8 then r9 written, wb_stall=1.
  - Cycle 7: the stalled r5 write is granted.
- Fill buffer (2 entries) with pipe continuously writing -> md_ready=0, and a third md_valid is not enqueued until md_ready rises.
- Buffered entry for r7 plus flush=1 with pipe_wen=1, pipe_wsel=7 -> r7 buffered value written, wb_stall=0, pipe value never reaches rf.
